core_dec_issue: RTL and testbench

// Parametrised decode/issue stage for the Selen RV32I pipeline; successor to the single-register decode stage.

---
 rtl/core_dec_issue.sv | 237 +++++++++++++++++++++++
 tb/tb_core_dec_issue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dec_issue.sv
// Decode/issue stage: instruction FIFO, RV32I decode, register file with writeback bypass,
// per-register pending scoreboard and a decode->execute register.
module core_dec_issue #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int IBUF_DEPTH = 2,
    localparam int RW        = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            kill,
    input  logic            wb_we,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_pc_4,
    output logic [XLEN-1:0] ex_src1,
    output logic [XLEN-1:0] ex_src2,
    output logic [XLEN-1:0] ex_imm,
    output logic [3:0]      ex_cls,
    output logic [2:0]      ex_funct3,
    output logic            ex_f7b5,
    output logic [RW-1:0]   ex_rd,
    output logic            ex_we
);
    localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int CW = $clog2(IBUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(IBUF_DEPTH);

    localparam logic [3:0] CLS_R = 4'd0, CLS_I = 4'd1, CLS_LUI = 4'd2, CLS_AUIPC = 4'd3,
                           CLS_BR = 4'd4, CLS_JAL = 4'd5, CLS_JALR = 4'd6, CLS_LD = 4'd7,
                           CLS_ST = 4'd8, CLS_ILL = 4'd15;

    logic [31:0]      ibuf_inst_q [IBUF_DEPTH];
    logic [XLEN-1:0]  ibuf_pc_q   [IBUF_DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;

    logic            ex_valid_q, ex_valid_d, ex_f7b5_q, ex_f7b5_d, ex_we_q, ex_we_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d, ex_pc_4_q, ex_pc_4_d, ex_src1_q, ex_src1_d;
    logic [XLEN-1:0] ex_src2_q, ex_src2_d, ex_imm_q, ex_imm_d;
    logic [3:0]      ex_cls_q, ex_cls_d;
    logic [2:0]      ex_funct3_q, ex_funct3_d;
    logic [RW-1:0]   ex_rd_q, ex_rd_d;

    logic [31:0]     head_inst;
    logic [XLEN-1:0] head_pc;
    logic            head_valid;
    logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j, dec_imm32;
    logic [3:0]      dec_cls;
    logic            use_rs1, use_rs2, has_rd, dec_we;
    logic [RW-1:0]   rs1, rs2, dec_rd;
    logic [XLEN-1:0] rd1_val, rd2_val;
    logic            haz1, haz2, issue, handoff, push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (IBUF_DEPTH == 1) ? '0 : p + 1'b1;
    endfunction

    assign head_inst  = ibuf_inst_q[rd_ptr_q];
    assign head_pc    = ibuf_pc_q[rd_ptr_q];
    assign head_valid = (count_q != '0);

    assign imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
    assign imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
    assign imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
                    head_inst[11:8], 1'b0};
    assign imm_u = {head_inst[31:12], 12'b0};
    assign imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
                    head_inst[30:21], 1'b0};

    always_comb begin
        dec_cls   = CLS_ILL;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        has_rd    = 1'b0;
        dec_imm32 = '0;
        case (head_inst[6:0])
            7'b0110011: begin dec_cls = CLS_R;     use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1; end
            7'b0010011: begin dec_cls = CLS_I;     use_rs1 = 1'b1; has_rd = 1'b1; dec_imm32 = imm_i; end
            7'b0110111: begin dec_cls = CLS_LUI;   has_rd = 1'b1; dec_imm32 = imm_u; end
            7'b0010111: begin dec_cls = CLS_AUIPC; has_rd = 1'b1; dec_imm32 = imm_u; end
            7'b1100011: begin dec_cls = CLS_BR;    use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm32 = imm_b; end
            7'b1101111: begin dec_cls = CLS_JAL;   has_rd = 1'b1; dec_imm32 = imm_j; end
            7'b1100111: begin dec_cls = CLS_JALR;  use_rs1 = 1'b1; has_rd = 1'b1; dec_imm32 = imm_i; end
            7'b0000011: begin dec_cls = CLS_LD;    use_rs1 = 1'b1; has_rd = 1'b1; dec_imm32 = imm_i; end
            7'b0100011: begin dec_cls = CLS_ST;    use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm32 = imm_s; end
            default: ;
        endcase
    end

    assign rs1    = RW'(head_inst[19:15]);
    assign rs2    = RW'(head_inst[24:20]);
    assign dec_rd = has_rd ? RW'(head_inst[11:7]) : '0;
    assign dec_we = has_rd && (dec_rd != '0);

    // A same-cycle writeback is forwarded so an instruction can issue on the cycle its operand lands.
    always_comb begin
        rd1_val = '0;
        rd2_val = '0;
        if (use_rs1 && rs1 != '0) rd1_val = (wb_we && wb_rd == rs1) ? wb_data : regs_q[rs1];
        if (use_rs2 && rs2 != '0) rd2_val = (wb_we && wb_rd == rs2) ? wb_data : regs_q[rs2];
    end

    assign haz1 = use_rs1 && (rs1 != '0) &&
                  ((pending_q[rs1] && !(wb_we && wb_rd == rs1)) ||
                   (ex_valid_q && ex_we_q && ex_rd_q == rs1));
    assign haz2 = use_rs2 && (rs2 != '0) &&
                  ((pending_q[rs2] && !(wb_we && wb_rd == rs2)) ||
                   (ex_valid_q && ex_we_q && ex_rd_q == rs2));

    // Both ports are valid/ready: a beat moves on a cycle with valid & ready both high, and the
    // sender keeps valid and payload stable until then. if_ready may rise on a full FIFO that pops.
    assign issue    = head_valid && !haz1 && !haz2 && (!ex_valid_q || ex_ready) && !kill;
    assign handoff  = ex_valid_q && ex_ready;
    assign if_ready = (count_q != FULL_CNT) || issue;
    assign push     = if_valid && if_ready && !kill;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (kill) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push)  wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d = count_q + CW'(push) - CW'(issue);
        end
    end

    // Set after clear: a handoff and a writeback to the same register leave it pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_we) pending_d[wb_rd] = 1'b0;
        if (handoff && ex_we_q) pending_d[ex_rd_q] = 1'b1;
    end

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_pc_d     = ex_pc_q;
        ex_pc_4_d   = ex_pc_4_q;
        ex_src1_d   = ex_src1_q;
        ex_src2_d   = ex_src2_q;
        ex_imm_d    = ex_imm_q;
        ex_cls_d    = ex_cls_q;
        ex_funct3_d = ex_funct3_q;
        ex_f7b5_d   = ex_f7b5_q;
        ex_rd_d     = ex_rd_q;
        ex_we_d     = ex_we_q;
        if (kill) begin
            ex_valid_d = 1'b0;
        end else if (issue) begin
            ex_valid_d  = 1'b1;
            ex_pc_d     = head_pc;
            ex_pc_4_d   = head_pc + XLEN'(4);
            ex_src1_d   = rd1_val;
            ex_src2_d   = rd2_val;
            ex_imm_d    = XLEN'($signed(dec_imm32));
            ex_cls_d    = dec_cls;
            ex_funct3_d = head_inst[14:12];
            ex_f7b5_d   = head_inst[30];
            ex_rd_d     = dec_rd;
            ex_we_d     = dec_we;
        end else if (handoff) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
            ex_valid_q  <= 1'b0;
            ex_pc_q     <= '0;
            ex_pc_4_q   <= '0;
            ex_src1_q   <= '0;
            ex_src2_q   <= '0;
            ex_imm_q    <= '0;
            ex_cls_q    <= '0;
            ex_funct3_q <= '0;
            ex_f7b5_q   <= 1'b0;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            for (int i = 0; i < IBUF_DEPTH; i++) begin
                ibuf_inst_q[i] <= '0;
                ibuf_pc_q[i]   <= '0;
            end
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            ex_valid_q  <= ex_valid_d;
            ex_pc_q     <= ex_pc_d;
            ex_pc_4_q   <= ex_pc_4_d;
            ex_src1_q   <= ex_src1_d;
            ex_src2_q   <= ex_src2_d;
            ex_imm_q    <= ex_imm_d;
            ex_cls_q    <= ex_cls_d;
            ex_funct3_q <= ex_funct3_d;
            ex_f7b5_q   <= ex_f7b5_d;
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            if (push) begin
                ibuf_inst_q[wr_ptr_q] <= if_inst;
                ibuf_pc_q[wr_ptr_q]   <= if_pc;
            end
            if (wb_we && wb_rd != '0) regs_q[wb_rd] <= wb_data;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_pc     = ex_pc_q;
    assign ex_pc_4   = ex_pc_4_q;
    assign ex_src1   = ex_src1_q;
    assign ex_src2   = ex_src2_q;
    assign ex_imm    = ex_imm_q;
    assign ex_cls    = ex_cls_q;
    assign ex_funct3 = ex_funct3_q;
    assign ex_f7b5   = ex_f7b5_q;
    assign ex_rd     = ex_rd_q;
    assign ex_we     = ex_we_q;
endmodule

// File: tb/tb_core_dec_issue.sv
// Bench for core_dec_issue: directed scenarios followed by random traffic, all checked against
// a queue-based reference model of the fetch buffer, scoreboard and register file.
module tb_core_dec_issue;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, if_valid, if_ready, kill, wb_we, ex_valid, ex_ready, ex_f7b5, ex_we;
    logic [31:0] if_inst, if_pc, wb_data, ex_pc, ex_pc_4, ex_src1, ex_src2, ex_imm;
    logic [4:0]  wb_rd, ex_rd;
    logic [3:0]  ex_cls;
    logic [2:0]  ex_funct3;

    always #5 clk = ~clk;

    core_dec_issue #(.XLEN(32), .NREGS(32), .IBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
        .if_pc(if_pc), .kill(kill), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_pc_4(ex_pc_4),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_cls(ex_cls),
        .ex_funct3(ex_funct3), .ex_f7b5(ex_f7b5), .ex_rd(ex_rd), .ex_we(ex_we)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc, pc4, s1, s2, imm;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic        we;
    } ex_t;

    ex_t         m_ex;
    logic [63:0] exp_q[$];
    logic [31:0] m_pend;
    logic [31:0] m_rf[32];
    logic        last_acc;
    int          n_chk = 0;
    int          n_err = 0;
    logic [6:0]  opcs[9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h03, 7'h23};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction meaning from the ISA tables; immediates are rebuilt with integer arithmetic.
    function automatic void classify(input logic [31:0] w, output logic [3:0] cls, output logic u1,
                                     output logic u2, output logic wr, output logic [31:0] imm);
        int sv;
        sv = $signed(w);
        cls = 4'd15; u1 = 0; u2 = 0; wr = 0; imm = 0;
        case (w[6:0])
            7'h33: begin cls = 0; u1 = 1; u2 = 1; wr = 1; end
            7'h13: begin cls = 1; u1 = 1; wr = 1; imm = 32'(sv >>> 20); end
            7'h37: begin cls = 2; wr = 1; imm = w & 32'hFFFFF000; end
            7'h17: begin cls = 3; wr = 1; imm = w & 32'hFFFFF000; end
            7'h63: begin cls = 4; u1 = 1; u2 = 1;
                imm = 32'((sv >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
            end
            7'h6F: begin cls = 5; wr = 1;
                imm = 32'((sv >>> 31) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            end
            7'h67: begin cls = 6; u1 = 1; wr = 1; imm = 32'(sv >>> 20); end
            7'h03: begin cls = 7; u1 = 1; wr = 1; imm = 32'(sv >>> 20); end
            7'h23: begin cls = 8; u1 = 1; u2 = 1; imm = 32'((sv >>> 25) * 32 + int'(w[11:7])); end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] rs);
        if (rs == 0) return 0;
        if (wb_we && wb_rd == rs) return wb_data;
        return m_rf[rs];
    endfunction

    function automatic logic busy(input logic [4:0] rs);
        if (rs == 0) return 0;
        return (m_pend[rs] && !(wb_we && wb_rd == rs)) || (m_ex.v && m_ex.we && m_ex.rd == rs);
    endfunction

    // One clock: predict from current inputs, check if_ready, advance model, check ex outputs.
    task automatic tick();
        logic [3:0]  cls;
        logic        u1, u2, wr, iss, hand, exp_rdy, just_rst;
        logic [31:0] imm, inst, pc;
        ex_t         nx;
        #1;
        just_rst = rst;
        if (rst) begin
            exp_q.delete();
            m_ex = '{default: '0};
            m_pend = '0;
            foreach (m_rf[i]) m_rf[i] = '0;
            last_acc = 0;
        end else begin
            iss = 0;
            nx = m_ex;
            if (exp_q.size() > 0) begin
                {pc, inst} = exp_q[0];
                classify(inst, cls, u1, u2, wr, imm);
                iss = !((u1 && busy(inst[19:15])) || (u2 && busy(inst[24:20]))) &&
                      (!m_ex.v || ex_ready) && !kill;
                nx.v = 1; nx.pc = pc; nx.pc4 = pc + 32'd4; nx.imm = imm; nx.cls = cls;
                nx.s1 = u1 ? m_read(inst[19:15]) : 32'd0;
                nx.s2 = u2 ? m_read(inst[24:20]) : 32'd0;
                nx.f3 = inst[14:12]; nx.f7 = inst[30];
                nx.rd = wr ? inst[11:7] : 5'd0;
                nx.we = (nx.rd != 0);
            end
            exp_rdy = (exp_q.size() < DEPTH) || iss;
            chk("if_ready", if_ready, exp_rdy);
            last_acc = if_valid && exp_rdy && !kill;
            hand = m_ex.v && ex_ready;
            if (wb_we) m_pend[wb_rd] = 0;
            if (hand && m_ex.we) m_pend[m_ex.rd] = 1;
            if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
            if (kill) begin
                exp_q.delete();
                m_ex.v = 0;
            end else begin
                if (iss) begin
                    void'(exp_q.pop_front());
                    m_ex = nx;
                end else if (hand) begin
                    m_ex.v = 0;
                end
                if (last_acc) exp_q.push_back({if_pc, if_inst});
            end
        end
        @(posedge clk);
        #1;
        chk("ex_valid", ex_valid, m_ex.v);
        if (m_ex.v || just_rst) begin
            chk("ex_pc", ex_pc, m_ex.pc);
            chk("ex_pc_4", ex_pc_4, m_ex.pc4);
            chk("ex_src1", ex_src1, m_ex.s1);
            chk("ex_src2", ex_src2, m_ex.s2);
            chk("ex_imm", ex_imm, m_ex.imm);
            chk("ex_cls", ex_cls, m_ex.cls);
            chk("ex_funct3", ex_funct3, m_ex.f3);
            chk("ex_f7b5", ex_f7b5, m_ex.f7);
            chk("ex_rd", ex_rd, m_ex.rd);
            chk("ex_we", ex_we, m_ex.we);
        end
    endtask

    task automatic push_wait(input logic [31:0] inst, input logic [31:0] pc);
        if_inst = inst;
        if_pc = pc;
        if_valid = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("push_accepted", last_acc, 1'b1);
        if_valid = 0;
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 15) != 0) begin
            w[6:0] = opcs[$urandom_range(0, 8)];
            w[11:10] = 2'b0;
            w[19:18] = 2'b0;
            w[24:23] = 2'b0;
        end
        return w;
    endfunction

    initial begin
        rst = 1; if_valid = 0; if_inst = 0; if_pc = 0; kill = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; ex_ready = 0;
        tick();
        tick();
        rst = 0;
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_if_ready", if_ready, 1'b1);
        chk("rst_ex_imm", ex_imm, 32'd0);

        ex_ready = 1;
        push_wait(enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd5), 32'h100);
        tick();
        chk("addi_valid", ex_valid, 1'b1);
        chk("addi_imm", ex_imm, 32'd5);
        chk("addi_pc4", ex_pc_4, 32'h104);
        chk("addi_we", ex_we, 1'b1);
        chk("addi_rd", ex_rd, 5'd1);

        push_wait(enc_i(7'h03, 5'd2, 3'd2, 5'd0, 12'd0), 32'h104);
        push_wait(enc_r(5'd3, 5'd2, 5'd2), 32'h108);
        tick();
        wb_we = 1; wb_rd = 1; wb_data = 32'd5;
        tick();
        wb_we = 0;
        tick();
        chk("ld_use_stall", ex_valid, 1'b0);
        wb_we = 1; wb_rd = 2; wb_data = 32'd7;
        tick();
        wb_we = 0;
        chk("ld_use_issue", ex_valid, 1'b1);
        chk("ld_use_src1", ex_src1, 32'd7);
        chk("ld_use_src2", ex_src2, 32'd7);

        ex_ready = 0;
        push_wait(enc_i(7'h13, 5'd4, 3'd0, 5'd0, 12'd1), 32'h10C);
        push_wait(enc_i(7'h13, 5'd4, 3'd0, 5'd0, 12'd2), 32'h110);
        if_inst = enc_i(7'h13, 5'd4, 3'd0, 5'd0, 12'd3);
        if_pc = 32'h114;
        if_valid = 1;
        #1;
        chk("full_if_ready", if_ready, 1'b0);
        tick();
        kill = 1;
        tick();
        kill = 0;
        if_valid = 0;
        chk("kill_ex_valid", ex_valid, 1'b0);
        chk("kill_if_ready", if_ready, 1'b1);
        push_wait(enc_r(5'd5, 5'd3, 5'd1), 32'h300);
        tick();
        chk("kill_sb_clean", ex_valid, 1'b1);

        ex_ready = 1; wb_we = 1; wb_rd = 5; wb_data = 32'd9;
        if_inst = enc_r(5'd6, 5'd5, 5'd0);
        if_pc = 32'h304;
        if_valid = 1;
        tick();
        wb_we = 0;
        if_valid = 0;
        tick();
        tick();
        chk("set_wins_stall", ex_valid, 1'b0);
        wb_we = 1; wb_rd = 5; wb_data = 32'h33;
        tick();
        wb_we = 0;
        chk("set_wins_issue", ex_valid, 1'b1);
        chk("set_wins_src1", ex_src1, 32'h33);

        push_wait(enc_b(5'd0, 5'd0, 13'h1FFC), 32'h200);
        tick();
        chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
        chk("beq_cls", ex_cls, 4'd4);
        chk("beq_we", ex_we, 1'b0);
        push_wait(enc_r(5'd7, 5'd0, 5'd0), 32'h204);
        wb_we = 1; wb_rd = 0; wb_data = 32'hDEAD_BEEF;
        tick();
        wb_we = 0;
        chk("x0_issue", ex_valid, 1'b1);
        chk("x0_src1", ex_src1, 32'd0);

        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            kill = ($urandom_range(0, 29) == 0);
            if_valid = ($urandom_range(0, 3) != 0);
            if_inst = rand_inst();
            if_pc = $urandom;
            ex_ready = ($urandom_range(0, 3) != 0);
            wb_we = 1'($urandom_range(0, 1));
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
